// File: rtl/uart_rx_frontend_if.sv
// Byte-side bundle of the UART receive front end.
// master drives the holding register outputs; slave returns RX_ACK.
interface uart_rx_frontend_if;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic       RX_ACK;
   logic       RX_BUSY;
   logic       FRAME_ERR;
   logic       OVERRUN;

   modport master (
      output RX_DATA,
      output RX_VALID,
      output RX_BUSY,
      output FRAME_ERR,
      output OVERRUN,
      input  RX_ACK
   );

   modport slave (
      input  RX_DATA,
      input  RX_VALID,
      input  RX_BUSY,
      input  FRAME_ERR,
      input  OVERRUN,
      output RX_ACK
   );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: line synchroniser, start validation, mid-bit sampling
// and a valid/ack holding register on the full-rate board clock.
module uart_rx_frontend #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic CLK,
   input  logic RST,
   input  logic UART_TXD_IN,
   uart_rx_frontend_if.master rx
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    idx, idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_q, data_n;
   logic          valid_q, valid_n;
   logic          ferr_q, ferr_n;
   logic          ovr_q, ovr_n;
   logic          sync1, rx_s, rx_p;
   logic [2:0]    warm;
   logic          fall;

   // The flops reset high, so a line held low through reset would look
   // like a fresh edge; arm detection only once rx_p holds a real sample.
   assign fall = warm[2] & rx_p & ~rx_s;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_p    <= 1'b1;
         warm    <= '0;
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1   <= UART_TXD_IN;
         rx_s    <= sync1;
         rx_p    <= rx_s;
         warm    <= {warm[1:0], 1'b1};
         state   <= state_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
         ovr_q   <= ovr_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      shreg_n = shreg;
      data_n  = data_q;
      valid_n = valid_q;
      ferr_n  = 1'b0;
      ovr_n   = 1'b0;

      if (rx.RX_ACK)
         valid_n = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (fall)
               state_n = START;
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[7:1]};
               if (idx == 3'd7)
                  state_n = STOP;
               else
                  idx_n = idx + 3'd1;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_n   = '0;
               state_n = IDLE;
               if (rx_s) begin
                  data_n  = shreg;
                  valid_n = 1'b1;
                  ovr_n   = valid_q & ~rx.RX_ACK;
               end else begin
                  ferr_n = 1'b1;
               end
            end
         end
      endcase
   end

   assign rx.RX_DATA   = data_q;
   assign rx.RX_VALID  = valid_q;
   assign rx.RX_BUSY   = (state != IDLE);
   assign rx.FRAME_ERR = ferr_q;
   assign rx.OVERRUN   = ovr_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend at 16 clocks per bit.
// Stimulus queues expected bytes; a forked monitor checks each delivery.
module tb_uart_rx_frontend;

   localparam int CPB = 16;

   logic CLK = 1'b0;
   logic RST;
   logic pin;

   uart_rx_frontend_if u_if ();

   uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .UART_TXD_IN (pin),
      .rx          (u_if.master)
   );

   always #5 CLK = ~CLK;

   int vectors;
   int miscompares;
   int ferr_seen, ovr_seen;
   int exp_ferr, exp_ovr;
   int lat_n, w, busy_n;
   logic [7:0] exp_q[$];
   logic       pv;
   logic [7:0] pd;
   logic [7:0] e;
   logic       deliv;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_bit();
      repeat (CPB) @(posedge CLK);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stp);
      pin = 1'b0;
      wait_bit();
      for (int i = 0; i < 8; i++) begin
         pin = b[i];
         wait_bit();
      end
      pin = stp;
      wait_bit();
   endtask

   task automatic do_ack();
      u_if.RX_ACK = 1'b1;
      @(posedge CLK);
      #1;
      u_if.RX_ACK = 1'b0;
      chk("ack_clears_valid", 32'(u_if.RX_VALID), 0);
   endtask

   task automatic monitor();
      pv = 1'b0;
      pd = 8'h00;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            deliv = (u_if.RX_VALID && !pv) || u_if.OVERRUN ||
                    (u_if.RX_VALID && pv && u_if.RX_DATA != pd);
            if (deliv) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_byte: got %0h expected none",
                           u_if.RX_DATA);
               end else begin
                  e = exp_q.pop_front();
                  chk("rx_byte", 32'(u_if.RX_DATA), 32'(e));
               end
            end
            if (u_if.FRAME_ERR) ferr_seen++;
            if (u_if.OVERRUN) ovr_seen++;
         end
         pv = u_if.RX_VALID;
         pd = u_if.RX_DATA;
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      ferr_seen = 0;
      ovr_seen = 0;
      exp_ferr = 0;
      exp_ovr = 0;
      RST = 1'b1;
      pin = 1'b1;
      u_if.RX_ACK = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_data", 32'(u_if.RX_DATA), 0);
      chk("rst_valid", 32'(u_if.RX_VALID), 0);
      chk("rst_busy", 32'(u_if.RX_BUSY), 0);
      chk("rst_ferr", 32'(u_if.FRAME_ERR), 0);
      chk("rst_ovr", 32'(u_if.OVERRUN), 0);
      RST = 1'b0;
      wait_bit();

      // basic byte with latency
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            lat_n = 0;
            do begin
               @(posedge CLK);
               #1;
               lat_n++;
            end while (!u_if.RX_VALID && lat_n < 400);
            chk("basic_latency", 32'(lat_n), 155);
            chk("basic_data", 32'(u_if.RX_DATA), 32'h A5);
            chk("basic_ferr", 32'(u_if.FRAME_ERR), 0);
         end
      join
      do_ack();
      wait_bit();

      // back-to-back with ack two cycles after valid
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h3C);
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            send_frame(8'h3C, 1'b1);
         end
         repeat (3) begin
            w = 0;
            while (!u_if.RX_VALID && w < 400) begin
               @(posedge CLK);
               #1;
               w++;
            end
            chk("b2b_valid_seen", 32'(u_if.RX_VALID), 1);
            repeat (2) @(posedge CLK);
            #1;
            do_ack();
         end
      join
      wait_bit();
      chk("b2b_no_ovr", 32'(ovr_seen), 32'(exp_ovr));

      // overrun without ack
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_ovr++;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_bit();
      chk("ovr_data", 32'(u_if.RX_DATA), 32'h22);
      chk("ovr_valid", 32'(u_if.RX_VALID), 1);
      chk("ovr_count", 32'(ovr_seen), 32'(exp_ovr));
      do_ack();

      // ack coincident with second stop sample
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      fork
         begin
            send_frame(8'h33, 1'b1);
            send_frame(8'h44, 1'b1);
         end
         begin
            repeat (314) @(posedge CLK);
            #1;
            u_if.RX_ACK = 1'b1;
            @(posedge CLK);
            #1;
            u_if.RX_ACK = 1'b0;
         end
      join
      wait_bit();
      chk("ackcoin_data", 32'(u_if.RX_DATA), 32'h44);
      chk("ackcoin_valid", 32'(u_if.RX_VALID), 1);
      chk("ackcoin_no_ovr", 32'(ovr_seen), 32'(exp_ovr));
      do_ack();

      // framing error then clean frame
      exp_ferr++;
      send_frame(8'h5A, 1'b0);
      pin = 1'b1;
      wait_bit();
      chk("ferr_count", 32'(ferr_seen), 32'(exp_ferr));
      chk("ferr_valid", 32'(u_if.RX_VALID), 0);
      chk("ferr_data", 32'(u_if.RX_DATA), 32'h44);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_bit();
      chk("after_ferr_valid", 32'(u_if.RX_VALID), 1);

      // glitch on idle line
      busy_n = 0;
      pin = 1'b0;
      for (int i = 0; i < 44; i++) begin
         if (i == 3) pin = 1'b1;
         @(posedge CLK);
         #1;
         if (u_if.RX_BUSY) busy_n++;
      end
      chk("glitch_busy_seen", 32'(busy_n > 0), 1);
      chk("glitch_busy_max", 32'(busy_n <= CPB / 2 + 1), 1);
      chk("glitch_idle", 32'(u_if.RX_BUSY), 0);
      chk("glitch_data", 32'(u_if.RX_DATA), 32'h5A);
      chk("glitch_ferr", 32'(ferr_seen), 32'(exp_ferr));

      // reset during bit 4 of 0xC3
      fork
         send_frame(8'hC3, 1'b1);
         begin
            repeat (88) @(posedge CLK);
            #1;
            RST = 1'b1;
            @(posedge CLK);
            #1;
            RST = 1'b0;
            chk("midrst_data", 32'(u_if.RX_DATA), 0);
            chk("midrst_valid", 32'(u_if.RX_VALID), 0);
            chk("midrst_busy", 32'(u_if.RX_BUSY), 0);
            chk("midrst_ferr", 32'(u_if.FRAME_ERR), 0);
            chk("midrst_ovr", 32'(u_if.OVERRUN), 0);
         end
      join
      wait_bit();
      chk("midrst_no_restart", 32'(u_if.RX_BUSY), 0);
      chk("midrst_no_byte", 32'(u_if.RX_VALID), 0);
      wait_bit();
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      wait_bit();
      chk("post_rst_valid", 32'(u_if.RX_VALID), 1);
      chk("post_rst_data", 32'(u_if.RX_DATA), 32'h81);
      do_ack();

      repeat (50) @(posedge CLK);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 0);
      chk("total_ferr", 32'(ferr_seen), 32'(exp_ferr));
      chk("total_ovr", 32'(ovr_seen), 32'(exp_ovr));
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
